// File: rtl/qout_pkg.sv
// Shared widths and FIFO entry layout for the quantized-output path (packer and out_buffer).
package qout_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefPack  = 4;
    localparam int unsigned DefDepth = 8;

    // One FIFO entry; field order matches the flat vector {data, strb, last} used by the packer.
    typedef struct packed {
        logic [DefPack*DefDataW-1:0] data;
        logic [DefPack-1:0]          strb;
        logic                        last;
    } qout_entry_t;

    // Bit width of one flattened FIFO entry.
    function automatic int unsigned entry_width(input int unsigned data_w, input int unsigned pack);
        return pack * data_w + pack + 1;
    endfunction

endpackage

// File: rtl/qout_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; full/empty/fill derived from the pointers.
module qout_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] fill_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];

    // Pointer advance on push and pop; both may happen in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since empty gates the read data.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
        end
    end

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                     (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
    assign fill_o  = wr_ptr_q - rd_ptr_q;
    // Drive zeros while empty so the output is defined out of reset.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

    overflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
    underflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/qout_packer.sv
// Packs a stream of quantized values into PACK-lane words and queues them for out_buffer.
module qout_packer
    import qout_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned PACK   = DefPack,
    parameter int unsigned DEPTH  = DefDepth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [PACK*DATA_W-1:0] out_data,
    output logic [PACK-1:0]        out_strb,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int unsigned EntryW = entry_width(DATA_W, PACK);
    localparam int unsigned LaneW  = $clog2(PACK);
    localparam logic [LaneW-1:0] LaneMax = LaneW'(PACK - 1);

    logic [LaneW-1:0]              lane_cnt_q, lane_cnt_d;
    // Only PACK-1 lanes are stored; the final lane comes straight from in_data.
    logic [PACK-2:0][DATA_W-1:0]   lanes_q, lanes_d;
    logic                          accept;
    logic                          word_done;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [PACK*DATA_W-1:0]        word_data;
    logic [PACK-1:0]               word_strb;
    logic [EntryW-1:0]             push_entry;
    logic [EntryW-1:0]             head_entry;

    // Conservative: ignores a same-cycle pop so out_ready never reaches in_ready.
    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign word_done = accept && ((lane_cnt_q == LaneMax) || in_last);

    // Lane counter and packing register next state.
    always_comb begin
        lane_cnt_d = lane_cnt_q;
        lanes_d    = lanes_q;
        if (accept) begin
            if (word_done) begin
                lane_cnt_d = '0;
            end else begin
                lane_cnt_d = lane_cnt_q + LaneW'(1);
            end
            for (int unsigned i = 0; i < PACK - 1; i++) begin
                if (lane_cnt_q == LaneW'(i)) begin
                    lanes_d[i] = in_data;
                end
            end
        end
    end

    // Assemble the completing word: stored lanes below lane_cnt, in_data at lane_cnt, zeros above.
    always_comb begin
        word_data = '0;
        word_strb = '0;
        for (int unsigned i = 0; i < PACK - 1; i++) begin
            if (LaneW'(i) < lane_cnt_q) begin
                word_data[i*DATA_W +: DATA_W] = lanes_q[i];
            end
        end
        for (int unsigned i = 0; i < PACK; i++) begin
            if (LaneW'(i) == lane_cnt_q) begin
                word_data[i*DATA_W +: DATA_W] = in_data;
            end
            if (LaneW'(i) <= lane_cnt_q) begin
                word_strb[i] = 1'b1;
            end
        end
    end

    // Packing state registers; reset drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt_q <= '0;
            lanes_q    <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            lanes_q    <= lanes_d;
        end
    end

    assign push_entry = {word_data, word_strb, in_last};

    qout_fifo #(
        .Width (EntryW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (word_done),
        .wdata_i (push_entry),
        .pop_i   (out_valid && out_ready),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fill)
    );

    assign out_valid                      = !fifo_empty;
    assign {out_data, out_strb, out_last} = head_entry;

endmodule

// File: tb/tb_qout_packer.sv
// Self-checking bench for qout_packer: scoreboard monitor plus per-scenario tasks.
module tb_qout_packer;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int DP = 8;

    typedef struct {
        logic [PK*DW-1:0] d;
        logic [PK-1:0]    s;
        logic             l;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic            in_ready;
    logic            out_valid;
    logic [PK*DW-1:0] out_data;
    logic [PK-1:0]   out_strb;
    logic            out_last;
    logic            out_ready;
    logic [3:0]      fill;

    int checks = 0;
    int passes = 0;
    int pop_count = 0;
    int push_count = 0;
    int send_cycles = 0;

    exp_t            exp_q [$];
    logic [DW-1:0]   m_lanes [PK];
    int              m_cnt = 0;
    bit              prev_stall = 0;
    logic [PK*DW-1:0] prev_d;
    logic [PK-1:0]   prev_s;
    logic            prev_l;
    logic [PK*DW-1:0] last_d = '0;
    logic [PK-1:0]   last_s = '0;
    logic            last_l = 1'b0;

    qout_packer #(
        .DATA_W (DW),
        .PACK   (PK),
        .DEPTH  (DP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_strb  (out_strb),
        .out_last  (out_last),
        .out_ready (out_ready),
        .fill      (fill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge where they take effect.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            prev_stall = 0;
        end else begin
            checks++;
            if (fill !== 4'(exp_q.size()))
                $display("FAIL mon_fill got %0d want %0d", fill, exp_q.size());
            else passes++;
            checks++;
            if (out_valid !== (exp_q.size() != 0))
                $display("FAIL mon_out_valid got %b want %b", out_valid, exp_q.size() != 0);
            else passes++;
            checks++;
            if (in_ready !== (exp_q.size() != DP))
                $display("FAIL mon_in_ready got %b want %b", in_ready, exp_q.size() != DP);
            else passes++;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_strb !== prev_s ||
                    out_last !== prev_l)
                    $display("FAIL mon_stall_stable got %b/%h/%h/%b want 1/%h/%h/%b",
                             out_valid, out_data, out_strb, out_last, prev_d, prev_s, prev_l);
                else passes++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_s = out_strb;
            prev_l = out_last;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL mon_unexpected_word got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_strb !== e.s || out_last !== e.l)
                        $display("FAIL mon_word got %h/%h/%b want %h/%h/%b",
                                 out_data, out_strb, out_last, e.d, e.s, e.l);
                    else passes++;
                end
                last_d = out_data;
                last_s = out_strb;
                last_l = out_last;
                pop_count++;
            end
            if (in_valid && in_ready) begin
                m_lanes[m_cnt] = in_data;
                if (m_cnt == PK - 1 || in_last) begin
                    e.d = '0;
                    e.s = '0;
                    for (int i = 0; i < PK; i++) begin
                        if (i <= m_cnt) begin
                            e.d[i*DW +: DW] = m_lanes[i];
                            e.s[i] = 1'b1;
                        end
                    end
                    e.l = in_last;
                    exp_q.push_back(e);
                    push_count++;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Offer one value until accepted; called and returns at posedge+1.
    task automatic send(input logic [DW-1:0] v, input logic l);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        in_valid = 1'b1;
        in_data = v;
        in_last = l;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        send_cycles = n;
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout got no accept want accept within 200 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (fill !== 4'd0) $display("FAIL drain_fill got %0d want 0", fill);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else passes++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else passes++;
        checks++;
        if (out_data !== '0 || out_strb !== '0 || out_last !== 1'b0)
            $display("FAIL reset_out_word got %h/%h/%b want 0/0/0", out_data, out_strb, out_last);
        else passes++;
        checks++;
        if (fill !== 4'd0) $display("FAIL reset_fill got %0d want 0", fill);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_full_words();
        int pc;
        pc = pop_count;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
        drain();
        checks++;
        if (pop_count - pc !== 2) $display("FAIL full_words_count got %0d want 2", pop_count - pc);
        else passes++;
        checks++;
        if (last_d !== 32'h08070605 || last_s !== 4'hF || last_l !== 1'b1)
            $display("FAIL full_words_last got %h/%h/%b want 08070605/f/1", last_d, last_s, last_l);
        else passes++;
    endtask

    task automatic test_partial();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(8'(8'h10 + i), i == 5);
        drain();
        checks++;
        if (last_d !== 32'h00001514 || last_s !== 4'h3 || last_l !== 1'b1)
            $display("FAIL partial_last got %h/%h/%b want 00001514/3/1", last_d, last_s, last_l);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int pc;
        int cyc;
        pc = pop_count;
        cyc = 0;
        out_ready = 1'b1;
        send(8'h21, 1'b1);
        cyc += send_cycles;
        for (int i = 0; i < 4; i++) begin
            send(8'(8'h22 + i), i == 3);
            cyc += send_cycles;
        end
        drain();
        checks++;
        if (cyc !== 5) $display("FAIL b2b_cycles got %0d want 5", cyc);
        else passes++;
        checks++;
        if (pop_count - pc !== 2) $display("FAIL b2b_count got %0d want 2", pop_count - pc);
        else passes++;
        checks++;
        if (last_d !== 32'h25242322 || last_s !== 4'hF || last_l !== 1'b1)
            $display("FAIL b2b_last got %h/%h/%b want 25242322/f/1", last_d, last_s, last_l);
        else passes++;
    endtask

    task automatic test_backpressure();
        int accepted;
        int first_block;
        int pc;
        accepted = 0;
        first_block = -1;
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h40 + i);
            in_last = 1'b0;
            @(negedge clk);
            if (in_ready) accepted++;
            else if (first_block < 0) first_block = i;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (accepted !== 32) $display("FAIL bp_accepted got %0d want 32", accepted);
        else passes++;
        checks++;
        if (first_block !== 32) $display("FAIL bp_first_block got %0d want 32", first_block);
        else passes++;
        checks++;
        if (fill !== 4'd8 || in_ready !== 1'b0)
            $display("FAIL bp_full got fill %0d ready %b want fill 8 ready 0", fill, in_ready);
        else passes++;
        pc = pop_count;
        drain();
        checks++;
        if (pop_count - pc !== 8) $display("FAIL bp_drained got %0d want 8", pop_count - pc);
        else passes++;
        checks++;
        if (last_d !== 32'h5f5e5d5c || last_s !== 4'hF || last_l !== 1'b0)
            $display("FAIL bp_last got %h/%h/%b want 5f5e5d5c/f/0", last_d, last_s, last_l);
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_resume got %b want 1", in_ready);
        else passes++;
    endtask

    task automatic test_full_pop();
        int pc;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(8'(i), 1'b0);
        pc = pop_count;
        in_valid = 1'b1;
        in_data = 8'h60;
        in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || fill !== 4'd8)
            $display("FAIL fullpop_c0 got ready %b fill %0d want ready 0 fill 8", in_ready, fill);
        else passes++;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || fill !== 4'd7)
            $display("FAIL fullpop_c1 got ready %b fill %0d want ready 1 fill 7", in_ready, fill);
        else passes++;
        @(posedge clk);
        #1;
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
        drain();
        checks++;
        if (pop_count - pc !== 9) $display("FAIL fullpop_count got %0d want 9", pop_count - pc);
        else passes++;
        checks++;
        if (last_d !== 32'h63626160 || last_s !== 4'hF || last_l !== 1'b1)
            $display("FAIL fullpop_last got %h/%h/%b want 63626160/f/1", last_d, last_s, last_l);
        else passes++;
    endtask

    task automatic test_random();
        int acc;
        int n;
        int pc;
        int pu;
        acc = 0;
        n = 0;
        pc = pop_count;
        pu = push_count;
        while (acc < 1000 && n < 20000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
            in_last = ($urandom_range(0, 7) == 0) || (acc == 999);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        drain();
        checks++;
        if (acc !== 1000) $display("FAIL rand_accepted got %0d want 1000", acc);
        else passes++;
        checks++;
        if (pop_count - pc !== push_count - pu)
            $display("FAIL rand_words got %0d want %0d", pop_count - pc, push_count - pu);
        else passes++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h71 + i), 1'b0);
        for (int i = 0; i < 3; i++) send(8'(8'h75 + i), 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fill !== 4'd0 || out_data !== '0)
            $display("FAIL rstmid_now got valid %b fill %0d data %h want 0/0/0",
                     out_valid, fill, out_data);
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", in_ready);
        else passes++;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), i == 3);
        drain();
        checks++;
        if (last_d !== 32'hA3A2A1A0 || last_s !== 4'hF || last_l !== 1'b1)
            $display("FAIL rstmid_next got %h/%h/%b want a3a2a1a0/f/1", last_d, last_s, last_l);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial();
        test_back_to_back();
        test_backpressure();
        test_full_pop();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
